// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared constants for the PWM dead-time generator.
//   - Default carrier peak, bus width, dead time and dead-time counter width.
//     These must match the ramp generator feeding this block.
//   - Dead-time FSM state type and 3-bit state encodings.
package pwm_deadtime_gen_pkg;

   // Carrier peak; the ramp runs 0..PRD_DEF..0.
   localparam int unsigned PRD_DEF       = 450;
   // Width of the ramp and duty buses.
   localparam int unsigned W_DEF         = 11;
   // Dead time in clock cycles (legal 1..255).
   localparam int unsigned DT_CYCLES_DEF = 5;
   // Dead-time counter width.
   localparam int unsigned DTW_DEF       = 8;

   localparam int unsigned STATE_W = 3;

   typedef logic [STATE_W-1:0] dt_state_t;

   localparam dt_state_t StIdle   = 3'd0;
   localparam dt_state_t StDtToHi = 3'd1;
   localparam dt_state_t StHi     = 3'd2;
   localparam dt_state_t StDtToLo = 3'd3;
   localparam dt_state_t StLo     = 3'd4;

endpackage

// File: rtl/pwm_deadtime_gen_deadtime_fsm.sv
// Shoot-through-safe dead-time state machine for one complementary gate pair.
//
// Ports:
//   clk_i      reference clock, posedge
//   rst_i      synchronous active-high reset
//   pwm_raw_i  registered comparator output (1 = upper switch wanted)
//   enable_i   gate enable; low forces both gates off on the next edge
//   fault_i    latched fault; high forces both gates off on the next edge
//   gate_hi_o  upper switch gate, registered
//   gate_lo_o  lower switch gate, registered
//
// Every transition into a conducting state passes through a DT state that
// holds both gates off for DT_CYCLES cycles. Turning off never waits.
module pwm_deadtime_gen_deadtime_fsm
   import pwm_deadtime_gen_pkg::*;
#(
   parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
   parameter int unsigned DTW       = DTW_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pwm_raw_i,
   input  logic enable_i,
   input  logic fault_i,
   output logic gate_hi_o,
   output logic gate_lo_o
);

   if ((DT_CYCLES < 1) || (DT_CYCLES > 255) || ((DT_CYCLES - 1) >= (1 << DTW)))
   begin : g_bad_dt
      $error("DT_CYCLES must be in 1..255 and DT_CYCLES-1 must fit in DTW bits");
   end

   localparam logic [DTW-1:0] DtLoad = DTW'(DT_CYCLES - 1);

   dt_state_t      state_q, state_d;
   logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
   logic           gate_hi_q, gate_lo_q;

   always_comb begin
      state_d  = state_q;
      dt_cnt_d = dt_cnt_q;

      if (!enable_i || fault_i) begin
         // Turn-off is always safe, so dead time is bypassed here.
         state_d  = StIdle;
         dt_cnt_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d  = pwm_raw_i ? StDtToHi : StDtToLo;
               dt_cnt_d = DtLoad;
            end
            StDtToHi: begin
               // A flip wins over expiry: pulses shorter than the dead time
               // are swallowed rather than producing a sliver of conduction.
               if (!pwm_raw_i) begin
                  state_d  = StDtToLo;
                  dt_cnt_d = DtLoad;
               end else if (dt_cnt_q == '0) begin
                  state_d = StHi;
               end else begin
                  dt_cnt_d = dt_cnt_q - DTW'(1);
               end
            end
            StDtToLo: begin
               if (pwm_raw_i) begin
                  state_d  = StDtToHi;
                  dt_cnt_d = DtLoad;
               end else if (dt_cnt_q == '0) begin
                  state_d = StLo;
               end else begin
                  dt_cnt_d = dt_cnt_q - DTW'(1);
               end
            end
            StHi: begin
               if (!pwm_raw_i) begin
                  state_d  = StDtToLo;
                  dt_cnt_d = DtLoad;
               end
            end
            StLo: begin
               if (pwm_raw_i) begin
                  state_d  = StDtToHi;
                  dt_cnt_d = DtLoad;
               end
            end
            default: begin
               state_d  = StIdle;
               dt_cnt_d = '0;
            end
         endcase
      end
   end

   // Gates decode the next state so each is a clean flop output; only one
   // of StHi/StLo can be state_d, so both gates can never be high together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         dt_cnt_q  <= '0;
         gate_hi_q <= 1'b0;
         gate_lo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dt_cnt_q  <= dt_cnt_d;
         gate_hi_q <= (state_d == StHi);
         gate_lo_q <= (state_d == StLo);
      end
   end

   assign gate_hi_o = gate_hi_q;
   assign gate_lo_o = gate_lo_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Carrier-compare PWM with double-buffered duty, dead time and latched trip.
// One instance per FCML switch pair, fed by that cell's phase-shifted ramp.
//
// Ports:
//   clk_i          reference clock, posedge
//   rst_i          synchronous active-high reset
//   ramp_ref_i     unsigned triangular carrier, 0..PRD
//   duty_ref_i     unsigned duty command
//   duty_valid_i   captures duty_ref_i into the shadow register
//   enable_i       gate enable; low forces both gates off
//   trip_i         fault source, sampled on clk_i and latched
//   trip_clr_i     clears the latched fault when trip_i is low
//   gate_hi_o      upper switch gate, registered
//   gate_lo_o      lower switch gate, registered
//   duty_active_o  duty currently used by the comparator
//   fault_o        latched trip status
module pwm_deadtime_gen
   import pwm_deadtime_gen_pkg::*;
#(
   parameter int unsigned PRD       = PRD_DEF,
   parameter int unsigned W         = W_DEF,
   parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
   parameter int unsigned DTW       = DTW_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] ramp_ref_i,
   input  logic [W-1:0] duty_ref_i,
   input  logic         duty_valid_i,
   input  logic         enable_i,
   input  logic         trip_i,
   input  logic         trip_clr_i,
   output logic         gate_hi_o,
   output logic         gate_lo_o,
   output logic [W-1:0] duty_active_o,
   output logic         fault_o
);

   // PRD+1 encodes 100% duty and must be representable.
   if ((PRD + 1) >= (1 << W)) begin : g_bad_prd
      $error("PRD+1 must fit in W bits");
   end

   localparam logic [W-1:0] PrdW     = W'(PRD);
   localparam logic [W-1:0] DutyFull = W'(PRD + 1);

   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] duty_active_q, duty_active_d;
   logic         pwm_raw_q, pwm_raw_d;
   logic         fault_q, fault_d;
   logic         at_extremum;

   assign at_extremum = (ramp_ref_i == '0) || (ramp_ref_i == PrdW);

   always_comb begin
      shadow_d = shadow_q;
      if (duty_valid_i) begin
         shadow_d = (duty_ref_i > DutyFull) ? DutyFull : duty_ref_i;
      end

      // Loads the pre-edge shadow, so a capture coinciding with an extremum
      // only takes effect at the following one.
      duty_active_d = duty_active_q;
      if (at_extremum) begin
         duty_active_d = shadow_q;
      end

      pwm_raw_d = (ramp_ref_i < duty_active_q);

      // Trip dominates clear.
      fault_d = fault_q;
      if (trip_i) begin
         fault_d = 1'b1;
      end else if (trip_clr_i) begin
         fault_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q      <= '0;
         duty_active_q <= '0;
         pwm_raw_q     <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         duty_active_q <= duty_active_d;
         pwm_raw_q     <= pwm_raw_d;
         fault_q       <= fault_d;
      end
   end

   pwm_deadtime_gen_deadtime_fsm #(
      .DT_CYCLES (DT_CYCLES),
      .DTW       (DTW)
   ) u_deadtime_fsm (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pwm_raw_i (pwm_raw_q),
      .enable_i  (enable_i),
      .fault_i   (fault_q),
      .gate_hi_o (gate_hi_o),
      .gate_lo_o (gate_lo_o)
   );

   assign duty_active_o = duty_active_q;
   assign fault_o       = fault_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: directed vector table for the duty buffering
// and fault latch, then hand-written sequences for gate timing.
module tb_pwm_deadtime_gen;

   localparam int P  = 450;
   localparam int DT = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] ramp = '0;
   logic [10:0] duty = '0;
   logic        dv = 1'b0;
   logic        en = 1'b0;
   logic        trip = 1'b0;
   logic        clr = 1'b0;
   logic        hi, lo, fault;
   logic [10:0] da;

   always #5 clk = ~clk;

   pwm_deadtime_gen #(
      .PRD       (450),
      .W         (11),
      .DT_CYCLES (5),
      .DTW       (8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ramp_ref_i    (ramp),
      .duty_ref_i    (duty),
      .duty_valid_i  (dv),
      .enable_i      (en),
      .trip_i        (trip),
      .trip_clr_i    (clr),
      .gate_hi_o     (hi),
      .gate_lo_o     (lo),
      .duty_active_o (da),
      .fault_o       (fault)
   );

   int total = 0;
   int bad   = 0;

   // Triangle carrier model: 0..450..1, period 900.
   int ramp_v = 0;
   int applied_ramp = 0;
   bit up = 1'b1;
   bit run = 1'b0;

   // Gate-rise tracking.
   int off_run = 0;
   int last_gap = 0;
   bit rise_evt = 1'b0;
   bit prev_on = 1'b0;

   typedef struct {
      int r_rst; int r_en; int r_ramp; int r_duty; int r_dv; int r_trip; int r_clr;
      int e_hi; int e_lo; int e_da; int e_fault;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task tick();
      ramp = ramp_v[10:0];
      applied_ramp = ramp_v;
      @(posedge clk);
      #1;
      if (run) begin
         if (up) begin
            if (ramp_v == P) begin up = 1'b0; ramp_v = P - 1; end
            else ramp_v = ramp_v + 1;
         end else begin
            if (ramp_v == 0) begin up = 1'b1; ramp_v = 1; end
            else ramp_v = ramp_v - 1;
         end
      end
      rise_evt = 1'b0;
      if (hi || lo) begin
         if (!prev_on) begin
            rise_evt = 1'b1;
            last_gap = off_run;
         end
         off_run = 0;
         prev_on = 1'b1;
      end else begin
         off_run = off_run + 1;
         prev_on = 1'b0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_rise(output int n_off, output int got_hi, output int got_lo);
      n_off = 0; got_hi = 0; got_lo = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (hi || lo) begin
            got_hi = int'(hi);
            got_lo = int'(lo);
            return;
         end
         n_off++;
      end
   endtask

   task automatic load_duty(input int d, input int exp_da, input string name);
      duty = 11'(d);
      dv = 1'b1;
      tick();
      dv = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (int'(da) == exp_da) break;
         tick();
      end
      check(name, int'(da), exp_da);
   endtask

   task automatic measure(input int n, output int hc, output int lc, output int ov,
                          output int gaps, output int badgap);
      hc = 0; lc = 0; ov = 0; gaps = 0; badgap = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         hc += int'(hi);
         lc += int'(lo);
         ov += int'(hi & lo);
         if (rise_evt) begin
            gaps++;
            if (last_gap != DT) badgap++;
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_off, g_hi, g_lo, hc, lc, ov, gaps, badgap, chg, found, was_hi;

      //            rst en ramp duty dv tr cl  hi lo  da  flt
      vecs[0]  = '{1, 1, 0,   200, 1, 0, 0,  0, 0, 0,   0};
      vecs[1]  = '{1, 1, 0,   200, 1, 0, 0,  0, 0, 0,   0};
      vecs[2]  = '{1, 1, 0,   200, 1, 0, 0,  0, 0, 0,   0};
      vecs[3]  = '{0, 0, 10,  300, 1, 0, 0,  0, 0, 0,   0};
      vecs[4]  = '{0, 0, 11,  0,   0, 0, 0,  0, 0, 0,   0};
      vecs[5]  = '{0, 0, 450, 0,   0, 0, 0,  0, 0, 300, 0};
      vecs[6]  = '{0, 0, 449, 600, 1, 0, 0,  0, 0, 300, 0};
      vecs[7]  = '{0, 0, 0,   0,   0, 0, 0,  0, 0, 451, 0};
      vecs[8]  = '{0, 0, 0,   100, 1, 0, 0,  0, 0, 451, 0};
      vecs[9]  = '{0, 0, 1,   0,   0, 0, 0,  0, 0, 451, 0};
      vecs[10] = '{0, 0, 450, 0,   0, 0, 0,  0, 0, 100, 0};
      vecs[11] = '{0, 0, 5,   0,   0, 1, 0,  0, 0, 100, 1};
      vecs[12] = '{0, 0, 5,   0,   0, 1, 1,  0, 0, 100, 1};
      vecs[13] = '{0, 0, 5,   0,   0, 0, 0,  0, 0, 100, 1};
      vecs[14] = '{0, 0, 5,   0,   0, 0, 1,  0, 0, 100, 0};
      vecs[15] = '{0, 0, 0,   0,   1, 0, 0,  0, 0, 100, 0};
      vecs[16] = '{0, 0, 450, 0,   0, 0, 0,  0, 0, 0,   0};

      run = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rst    = vecs[i].r_rst[0];
         en     = vecs[i].r_en[0];
         ramp_v = vecs[i].r_ramp;
         duty   = 11'(vecs[i].r_duty);
         dv     = vecs[i].r_dv[0];
         trip   = vecs[i].r_trip[0];
         clr    = vecs[i].r_clr[0];
         tick();
         check($sformatf("vec%0d gate_hi", i), int'(hi), vecs[i].e_hi);
         check($sformatf("vec%0d gate_lo", i), int'(lo), vecs[i].e_lo);
         check($sformatf("vec%0d duty_active", i), int'(da), vecs[i].e_da);
         check($sformatf("vec%0d fault", i), int'(fault), vecs[i].e_fault);
      end
      dv = 1'b0; trip = 1'b0; clr = 1'b0;

      // Reset held with enable and a pending duty, then first edge after DT.
      ramp_v = 0; up = 1'b1; run = 1'b1;
      rst = 1'b1; en = 1'b1; duty = 11'd200; dv = 1'b1;
      ticks(3);
      check("reset gates", int'(hi | lo), 0);
      check("reset duty_active", int'(da), 0);
      check("reset fault", int'(fault), 0);
      rst = 1'b0; dv = 1'b0;
      wait_rise(n_off, g_hi, g_lo);
      check("post-reset off cycles", n_off, DT);
      check("post-reset gate_lo", g_lo, 1);

      // Steady PWM at 50%.
      load_duty(225, 225, "load 225");
      ticks(900);
      measure(900, hc, lc, ov, gaps, badgap);
      check("steady hi count", hc, 444);
      check("steady lo count", lc, 446);
      check("steady overlap", ov, 0);
      check("steady gaps", gaps, 2);
      check("steady gap length", badgap, 0);

      // Mid-upslope capture takes effect only at the peak.
      for (int i = 0; i < 1000; i++) begin
         if (ramp_v == 100 && up) break;
         tick();
      end
      duty = 11'd100; dv = 1'b1;
      tick();
      dv = 1'b0;
      chg = -1;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (int'(da) != 225) begin chg = applied_ramp; break; end
      end
      check("update at ramp", chg, P);
      check("update value", int'(da), 100);

      // Trip while the upper gate conducts.
      found = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (rise_evt && hi) begin found = 1; break; end
      end
      check("found gate_hi rise", found, 1);
      ticks(10);
      trip = 1'b1;
      tick();
      check("trip latch", int'(fault), 1);
      trip = 1'b0;
      tick();
      check("trip gates off", int'(hi | lo), 0);
      ticks(3);
      check("fault held", int'(fault), 1);
      check("fault gates held off", int'(hi | lo), 0);
      clr = 1'b1;
      tick();
      check("fault cleared", int'(fault), 0);
      clr = 1'b0;
      wait_rise(n_off, g_hi, g_lo);
      check("post-clear off cycles", n_off, DT);
      check("post-clear gate_hi", g_hi, 1);

      // Disable mid-dead-time, then re-enable: full dead time again.
      found = 0; was_hi = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (was_hi && !hi) begin found = 1; break; end
         was_hi = int'(hi);
      end
      check("found gate_hi fall", found, 1);
      ticks(2);
      en = 1'b0;
      tick();
      check("disable mid-dt gates", int'(hi | lo), 0);
      en = 1'b1;
      wait_rise(n_off, g_hi, g_lo);
      check("re-enable off cycles", n_off, DT);
      check("re-enable gate_lo", g_lo, 1);
      ticks(3);
      en = 1'b0;
      tick();
      check("disable while lo on", int'(lo), 0);
      en = 1'b1;

      // Duty extremes and a pulse shorter than the dead time.
      load_duty(0, 0, "load 0");
      ticks(900);
      measure(900, hc, lc, ov, gaps, badgap);
      check("duty0 hi count", hc, 0);
      check("duty0 lo count", lc, 900);

      load_duty(600, 451, "load 600 saturates");
      ticks(900);
      measure(900, hc, lc, ov, gaps, badgap);
      check("duty451 hi count", hc, 900);
      check("duty451 lo count", lc, 0);

      load_duty(3, 3, "load 3");
      ticks(900);
      measure(900, hc, lc, ov, gaps, badgap);
      check("short pulse hi count", hc, 0);
      check("short pulse lo count", lc, 890);
      check("short pulse overlap", ov, 0);

      // Random ramp/duty/enable/trip traffic: no overlap, every turn-on
      // preceded by at least a full dead time.
      for (int i = 0; i < 3000; i++) begin
         dv   = ($urandom_range(0, 15) == 0);
         duty = 11'($urandom_range(0, 700));
         if ($urandom_range(0, 99) == 0) en = ~en;
         trip = ($urandom_range(0, 299) == 0);
         clr  = ($urandom_range(0, 49) == 0);
         rst  = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 199) == 0) ramp_v = $urandom_range(0, P);
         tick();
         check("random overlap", int'(hi & lo), 0);
         if (rise_evt) check("random dead time", int'(last_gap >= DT), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
